// File: rtl/bram_burst_reader_pkg.sv
// Shared types and defaults for the BRAM burst read path (package mem_rd_pkg).
package mem_rd_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W_DEFAULT = 8;
  localparam logic [DATA_W_DEFAULT-1:0] CHECKSUM_INIT = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bram_burst_reader_if.sv
// BRAM read port plus downstream valid/ready byte stream.
interface bram_burst_reader_if #(
  parameter int ADDR_W = mem_rd_pkg::ADDR_W_DEFAULT,
  parameter int DATA_W = mem_rd_pkg::DATA_W_DEFAULT
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_addr, mem_rd_en, out_data, out_valid,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, out_data, out_valid,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/bram_burst_reader_rd_out_buf.sv
// Small synchronous FIFO holding returned BRAM bytes; head is presented directly
// from storage so the stream valid never depends on ready.
module rd_out_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head presentation; data forced to zero while empty
  always_comb begin
    count      = count_r;
    head_valid = (count_r != {CNT_W{1'b0}});
    if (head_valid) begin
      head_data = mem_r[rd_ptr_r];
    end else begin
      head_data = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/bram_burst_reader.sv
// Burst reader: issues sequential BRAM reads and streams bytes out with backpressure.
// Optional macro BURST_CHECKSUM_EN adds an XOR checksum output of the transferred beats.
module bram_burst_reader
  import mem_rd_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 2
) (
  input  logic              clk_mem,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        burst_len,
  output logic              busy,
  output logic              done,
`ifdef BURST_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  bram_burst_reader_if.master bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  if (RD_LATENCY != 1 || BUF_DEPTH < RD_LATENCY + 1) begin : g_param_check
    $error("bram_burst_reader: RD_LATENCY must be 1 and BUF_DEPTH >= RD_LATENCY+1");
  end

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        remaining_r;
  logic              inflight_r;
  logic              busy_r;
  logic              done_r;

  logic [CNT_W-1:0]  buf_count_s;
  logic [DATA_W-1:0] head_data_s;
  logic              head_valid_s;
  logic              pop_s;
  logic              issue_s;
  logic [OCC_W-1:0]  occupancy_s;

  // The read returns the cycle after issue, so inflight_r doubles as the push strobe
  rd_out_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk        (clk_mem),
    .reset      (reset),
    .push       (inflight_r),
    .push_data  (bus.mem_rd_data),
    .pop        (pop_s),
    .count      (buf_count_s),
    .head_data  (head_data_s),
    .head_valid (head_valid_s)
  );

  // Issue decision: occupancy after this cycle's pop must leave room for one more read
  always_comb begin
    pop_s       = head_valid_s && bus.out_ready;
    occupancy_s = OCC_W'(buf_count_s) + OCC_W'(inflight_r) - OCC_W'(pop_s);
    if (state_r == ISSUE && remaining_r != 8'd0) begin
      issue_s = (occupancy_s < OCC_W'(BUF_DEPTH));
    end else begin
      issue_s = 1'b0;
    end
  end

`ifdef BURST_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_r;
`endif

  // Burst control FSM with registered busy/done
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      remaining_r <= 8'd0;
      inflight_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef BURST_CHECKSUM_EN
      checksum_r  <= DATA_W'(CHECKSUM_INIT);
`endif
    end else begin
      inflight_r <= issue_s;
      done_r     <= 1'b0;
`ifdef BURST_CHECKSUM_EN
      if (pop_s) begin
        checksum_r <= checksum_r ^ head_data_s;
      end
`endif
      case (state_r)
        IDLE: begin
          if (start) begin
            busy_r <= 1'b1;
`ifdef BURST_CHECKSUM_EN
            checksum_r <= DATA_W'(CHECKSUM_INIT);
`endif
            if (burst_len != 8'd0) begin
              addr_r      <= base_addr;
              remaining_r <= burst_len;
              state_r     <= ISSUE;
            end else begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ISSUE: begin
          if (issue_s) begin
            addr_r      <= addr_r + ADDR_W'(1);
            remaining_r <= remaining_r - 8'd1;
            if (remaining_r == 8'd1) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Empty once the last beat leaves this cycle with nothing still returning
          if (occupancy_s == {OCC_W{1'b0}}) begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = addr_r;
  assign bus.mem_rd_en = issue_s;
  assign bus.out_data  = head_data_s;
  assign bus.out_valid = head_valid_s;
  assign busy          = busy_r;
  assign done          = done_r;
`ifdef BURST_CHECKSUM_EN
  assign checksum      = checksum_r;
`endif

endmodule
